nmr_scan_sequencer: RTL and testbench

- Initiator side of the acquisition-FSM configuration/status interface; sits between the PS-written register bank and the acquisition FSM.
- Drives the FSM's 193-bit cfg word through the reset-release / enable handshake and watches the FSM status word for completion.
- Repeats the scan n_scans times for signal averaging, with a fixed recovery delay between scans and a timeout watchdog.

---
 rtl/nmr_scan_sequencer_if.sv | 9 +
 rtl/nmr_scan_sequencer.sv | 179 +++++++++++++++++
 tb/tb_nmr_scan_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nmr_scan_sequencer_if.sv
// Config/status link between the scan sequencer (master) and the acquisition FSM (slave):
// 193-bit cfg word out, 32-bit status word back.
interface nmr_scan_sequencer_if;
    logic [192:0] cfg_o;
    logic [31:0]  sts_i;

    modport master (output cfg_o, input sts_i);
    modport slave  (input cfg_o, output sts_i);
endinterface

// File: rtl/nmr_scan_sequencer.sv
// nmr_scan_sequencer: steps the acquisition FSM through reset-hold, release and enable for
// n_scans averaged scans. Define NMR_SEQ_PHASE_CYCLE_EN to negate the amplitude on odd scans.
module nmr_scan_sequencer #(
    parameter int unsigned SETUP_CYCLES    = 12,
    parameter int unsigned RECOVERY_CYCLES = 1000,
    parameter int unsigned TIMEOUT_CYCLES  = 16777216
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [15:0]          n_scans,
    input  logic [15:0]          amplitude,
    input  logic [31:0]          size,
    input  logic [31:0]          nb_of_sample,
    input  logic [31:0]          freq,
    input  logic [31:0]          exc_time,
    input  logic [31:0]          acq_time,
    nmr_scan_sequencer_if.master fsm,
    output logic                 busy,
    output logic [15:0]          scan_cnt,
    output logic                 run_done,
    output logic                 timeout_err,
    output logic [2:0]           state_dbg
);

    // Handshake: start is a one-cycle request accepted only in IDLE and ignored otherwise;
    // abort is a level that wins over everything. Toward the FSM, cfg[0] releases its reset,
    // cfg[1] enables the scan, and sts[0] is a done level that is only looked at in ENABLE.

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD_RST, S_RELEASE, S_ENABLE, S_RECOVER, S_ERROR
    } state_t;

    localparam logic [31:0] SETUP_LAST   = (SETUP_CYCLES    > 0) ? 32'(SETUP_CYCLES - 1)    : 32'd0;
    localparam logic [31:0] RECOVER_LAST = (RECOVERY_CYCLES > 0) ? 32'(RECOVERY_CYCLES - 1) : 32'd0;
    localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYCLES  > 0) ? 32'(TIMEOUT_CYCLES - 1)  : 32'd0;

    state_t       state_q, state_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [15:0]  scan_cnt_d;
    logic [15:0]  n_eff_q;
    logic [192:0] cfg_q;
    logic [1:0]   ctrl_d;
    logic         accept;
    logic         done_pulse;
    logic         to_err;
    logic         unused_sts;

    assign fsm.cfg_o  = cfg_q;
    assign state_dbg  = state_q;
    assign unused_sts = ^fsm.sts_i[31:1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scan_cnt_d = scan_cnt;
        accept     = 1'b0;
        done_pulse = 1'b0;
        to_err     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_d    = S_HOLD_RST;
                    cnt_d      = '0;
                    scan_cnt_d = '0;
                end
            end
            S_HOLD_RST, S_RELEASE: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = (state_q == S_HOLD_RST) ? S_RELEASE : S_ENABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_ENABLE: begin
                // Done is checked before the watchdog so a done on the last allowed cycle counts.
                if (fsm.sts_i[0]) begin
                    scan_cnt_d = scan_cnt + 16'd1;
                    cnt_d      = '0;
                    if ((scan_cnt + 16'd1) == n_eff_q) begin
                        done_pulse = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = (RECOVERY_CYCLES == 0) ? S_HOLD_RST : S_RECOVER;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    to_err  = 1'b1;
                    state_d = S_ERROR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RECOVER: begin
                if (cnt_q == RECOVER_LAST) begin
                    state_d = S_HOLD_RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            scan_cnt_d = scan_cnt;
            accept     = 1'b0;
            done_pulse = 1'b0;
            to_err     = 1'b0;
        end
    end

    always_comb begin
        ctrl_d = 2'b00;
        case (state_d)
            S_RELEASE: ctrl_d = 2'b01;
            S_ENABLE:  ctrl_d = 2'b11;
            default:   ctrl_d = 2'b00;
        endcase
    end

`ifdef NMR_SEQ_PHASE_CYCLE_EN
    logic [15:0] amp_q;
    logic [15:0] amp_src;
    logic [15:0] amp_field;
    logic        enter_hold;

    assign enter_hold = (state_d == S_HOLD_RST) && (state_q != S_HOLD_RST);

    // The scan count seen on HOLD_RST entry picks the phase; -0x8000 saturates to 0x7FFF.
    always_comb begin
        amp_src   = accept ? amplitude : amp_q;
        amp_field = amp_src;
        if (scan_cnt_d[0])
            amp_field = (amp_src == 16'h8000) ? 16'h7FFF : (16'd0 - amp_src);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      amp_q <= '0;
        else if (accept) amp_q <= amplitude;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            scan_cnt    <= '0;
            n_eff_q     <= '0;
            cfg_q       <= '0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            scan_cnt    <= scan_cnt_d;
            busy        <= (state_d != S_IDLE);
            run_done    <= done_pulse;
            cfg_q[1:0]  <= ctrl_d;
            if (to_err)      timeout_err <= 1'b1;
            else if (accept) timeout_err <= 1'b0;
            if (accept) begin
                cfg_q[192:32] <= {1'b0, acq_time, exc_time, freq, nb_of_sample, size};
                cfg_q[31:16]  <= amplitude;
                n_eff_q       <= (n_scans == 16'd0) ? 16'd1 : n_scans;
            end
`ifdef NMR_SEQ_PHASE_CYCLE_EN
            if (enter_hold) cfg_q[31:16] <= amp_field;
`endif
        end
    end

endmodule

// File: tb/tb_nmr_scan_sequencer.sv
// tb_nmr_scan_sequencer: randomized runs checked against a scan-level reference model; a
// negedge monitor turns cfg/busy activity into segment and run-end records and scores them.
module tb_nmr_scan_sequencer;
    localparam int SETUP = 12;
    localparam int RECOV = 20;
    localparam int TMO   = 100;
    localparam int W     = 64;
    localparam logic [1:0] SEG  = 2'b01;
    localparam logic [1:0] ENDR = 2'b10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0, abort = 1'b0;
    logic [15:0] n_scans = '0, amplitude = '0;
    logic [31:0] size = '0, nb_of_sample = '0, freq = '0, exc_time = '0, acq_time = '0;
    logic        busy, run_done, timeout_err;
    logic [15:0] scan_cnt;
    logic [2:0]  state_dbg;
    logic [31:0] sts_drv = '0;

    nmr_scan_sequencer_if fsm_if ();
    assign fsm_if.sts_i = sts_drv;

    nmr_scan_sequencer #(
        .SETUP_CYCLES(SETUP), .RECOVERY_CYCLES(RECOV), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .n_scans(n_scans), .amplitude(amplitude), .size(size),
        .nb_of_sample(nb_of_sample), .freq(freq), .exc_time(exc_time),
        .acq_time(acq_time), .fsm(fsm_if), .busy(busy), .scan_cnt(scan_cnt),
        .run_done(run_done), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];
    logic [174:0] pay_q[$];
    int plan_dly[$];
    int dly_q[$];

    function automatic logic [W-1:0] mk(input logic [1:0] tag, input logic [1:0] ctrl,
                                        input int a, input int b, input int c);
        logic [15:0] fa, fb, fc;
        fa = a[15:0];
        fb = b[15:0];
        fc = c[15:0];
        return {tag, ctrl, fa, fb, fc, 12'd0};
    endfunction

    // Amplitude the FSM should see on scan k (0-based).
    function automatic logic [15:0] amp_for(input logic [15:0] amp, input int k);
        int s;
        s = int'($signed(amp));
`ifdef NMR_SEQ_PHASE_CYCLE_EN
        if (k % 2 == 1) begin
            s = -s;
            if (s > 32767) s = 32767;
        end
`endif
        return s[15:0];
    endfunction

    // Expected run: per scan a busy 00 stretch (hold, plus recovery after the first), a 01
    // stretch, an 11 stretch lasting the done delay; then a run-end record.
    task automatic model_run(input int n_req, input logic [15:0] amp,
                             input int abort_scan, input int abort_len);
        int n_eff;
        int d;
        logic [15:0] ak;
        n_eff = (n_req == 0) ? 1 : n_req;
        for (int k = 0; k < n_eff; k++) begin
            ak = amp_for(amp, k);
            d  = (k < plan_dly.size()) ? plan_dly[k] : 1;
            exp_q.push_back(mk(SEG, 2'b00, (k == 0) ? SETUP : RECOV + SETUP, ak, k));
            if (k == abort_scan) begin
                exp_q.push_back(mk(SEG, 2'b01, abort_len, ak, k));
                exp_q.push_back(mk(ENDR, 2'b00, 0, 0, k));
                return;
            end
            exp_q.push_back(mk(SEG, 2'b01, SETUP, ak, k));
            if (d == 0) begin
                exp_q.push_back(mk(SEG, 2'b11, TMO, ak, k));
                exp_q.push_back(mk(SEG, 2'b00, 1, ak, k));
                exp_q.push_back(mk(ENDR, 2'b00, 0, 1, k));
                return;
            end
            exp_q.push_back(mk(SEG, 2'b11, d, ak, k));
        end
        exp_q.push_back(mk(ENDR, 2'b00, 1, 0, n_eff));
    endtask

    task automatic score(input string name, input logic [W-1:0] got);
        logic [W-1:0] exp;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected record got=%h required=none", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s got=%h required=%h", name, got, exp);
            end
        end
    endtask

    task automatic chk(input string name, input logic [192:0] got, input logic [192:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    // ---------------- acquisition FSM responder ----------------
    int en_cnt = 0;
    int cur_d = 0;
    bit armed = 1'b0;
    always @(negedge clk) begin
        if (!rst_n || fsm_if.cfg_o[0] == 1'b0) begin
            sts_drv = $urandom & 32'hFFFF_FFFE;
            en_cnt  = 0;
            armed   = 1'b0;
        end else if (fsm_if.cfg_o[1:0] == 2'b11) begin
            if (!armed) begin
                armed = 1'b1;
                cur_d = (dly_q.size() > 0) ? dly_q.pop_front() : 1;
            end
            en_cnt++;
            if (cur_d != 0 && en_cnt >= cur_d) sts_drv[0] = 1'b1;
        end
    end

    // ---------------- monitor ----------------
    logic [2:0]  prev_key = 3'b000;
    int          seg_len = 0;
    int          rd_cnt = 0;
    logic [15:0] last_amp = '0;
    logic [15:0] last_scan = '0;
    always @(negedge clk) begin
        logic [2:0]   key;
        logic [174:0] pexp;
        key = {busy, fsm_if.cfg_o[1:0]};
        if (!rst_n) begin
            prev_key = 3'b000;
            seg_len  = 0;
            rd_cnt   = 0;
        end else begin
            if (key != prev_key) begin
                if (prev_key[2]) score("segment", mk(SEG, prev_key[1:0], seg_len, last_amp, last_scan));
                if (key[2] && !prev_key[2]) rd_cnt = 0;
                seg_len = 0;
            end
            if (run_done) rd_cnt++;
            if (!key[2] && prev_key[2]) begin
                score("run_end", mk(ENDR, 2'b00, rd_cnt, timeout_err, scan_cnt));
                n_vec++;
                if (pay_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL payload unexpected run end");
                end else begin
                    pexp = pay_q.pop_front();
                    if ({fsm_if.cfg_o[192:32], fsm_if.cfg_o[15:2]} !== pexp) begin
                        n_fail++;
                        $display("FAIL payload got=%h required=%h",
                                 {fsm_if.cfg_o[192:32], fsm_if.cfg_o[15:2]}, pexp);
                    end
                end
            end
            seg_len++;
            last_amp  = fsm_if.cfg_o[31:16];
            last_scan = scan_cnt;
            prev_key  = key;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue_start(input int n_req, input logic [15:0] amp, input logic [31:0] sz,
                               input logic [31:0] nb, input logic [31:0] fq,
                               input logic [31:0] ex, input logic [31:0] aq,
                               input int abort_scan, input int abort_len);
        dly_q = plan_dly;
        model_run(n_req, amp, abort_scan, abort_len);
        pay_q.push_back({1'b0, aq, ex, fq, nb, sz, 14'd0});
        @(negedge clk);
        n_scans = n_req[15:0]; amplitude = amp; size = sz; nb_of_sample = nb;
        freq = fq; exc_time = ex; acq_time = aq; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_scans = $urandom; amplitude = $urandom; size = $urandom; nb_of_sample = $urandom;
        freq = $urandom; exc_time = $urandom; acq_time = $urandom;
    endtask

    task automatic do_run(input int n_req, input logic [15:0] amp, input logic [31:0] sz,
                          input logic [31:0] nb, input logic [31:0] fq, input logic [31:0] ex,
                          input logic [31:0] aq, input int abort_scan, input int abort_len,
                          input bit poke);
        int guard;
        int seen;
        logic [1:0] pc;
        issue_start(n_req, amp, sz, nb, fq, ex, aq, abort_scan, abort_len);
        if (abort_scan >= 0) begin
            seen = 0; pc = 2'b00; guard = 0;
            while (seen < abort_scan + 1 && guard < 5000) begin
                if (fsm_if.cfg_o[1:0] == 2'b01 && pc != 2'b01) seen++;
                pc = fsm_if.cfg_o[1:0];
                if (seen < abort_scan + 1) begin
                    @(negedge clk);
                    guard++;
                end
            end
            n_vec++;
            if (seen < abort_scan + 1) begin
                n_fail++;
                $display("FAIL abort_sync release seen=%0d required=%0d", seen, abort_scan + 1);
            end
            repeat (abort_len - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        if (poke) begin
            repeat (30) @(negedge clk);
            n_scans = $urandom; amplitude = $urandom; size = $urandom; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        guard = 0;
        while (busy !== 1'b0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL run_finish busy=%b required=0 after %0d cycles", busy, guard);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cfg"}, fsm_if.cfg_o, '0);
        chk({tag, "_busy"}, {192'd0, busy}, '0);
        chk({tag, "_scan_cnt"}, {177'd0, scan_cnt}, '0);
        chk({tag, "_run_done"}, {192'd0, run_done}, '0);
        chk({tag, "_timeout_err"}, {192'd0, timeout_err}, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int ab;
        int guard;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        plan_dly = '{50};
        do_run(1, 16'd1024, 32'd1025, 32'd1026, 32'd1027, 32'hC, 32'hC, -1, 0, 1'b0);

        plan_dly = '{$urandom_range(1, 60), $urandom_range(1, 60), $urandom_range(1, 60)};
        do_run(3, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, -1, 0, 1'b1);

        plan_dly = '{0};
        do_run(2, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, -1, 0, 1'b0);
        chk("timeout_sticky", {192'd0, timeout_err}, 193'd1);

        plan_dly = '{$urandom_range(1, 40), $urandom_range(1, 40), 5, 5};
        do_run(4, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 1,
               $urandom_range(1, SETUP), 1'b0);

        plan_dly = '{TMO, 7};
        do_run(2, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, -1, 0, 1'b0);

        plan_dly = '{9};
        do_run(0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, -1, 0, 1'b0);

        plan_dly = '{20, 20};
        do_run(2, 16'd1024, $urandom, $urandom, $urandom, $urandom, $urandom, -1, 0, 1'b0);

        plan_dly = '{5, 5, 5};
        do_run(3, 16'h8000, $urandom, $urandom, $urandom, $urandom, $urandom, -1, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            n  = $urandom_range(1, 4);
            ab = (n > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
            plan_dly.delete();
            for (int k = 0; k < n; k++)
                plan_dly.push_back((ab < 0 && $urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 80));
            do_run(n, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, ab,
                   $urandom_range(1, SETUP), 1'b0);
        end

        // Asynchronous reset in the middle of ENABLE.
        plan_dly = '{0};
        issue_start(2, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, -1, 0);
        guard = 0;
        while (fsm_if.cfg_o[1:0] != 2'b11 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_enable", {191'd0, fsm_if.cfg_o[1:0]}, 193'd3);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        pay_q.delete();
        dly_q.delete();
        #1 check_reset_values("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        plan_dly = '{$urandom_range(1, 30), $urandom_range(1, 30)};
        do_run(2, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, -1, 0, 1'b0);

        chk("exp_q_drained", 193'(exp_q.size()), '0);
        chk("pay_q_drained", 193'(pay_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
